divider: RTL and testbench

Sequential unsigned integer divider, the inverse operation of the team's registered truncating multiplier. It computes `a / b` and `a % b` for BIT_SZ-bit operands using restoring division, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath and uses a start/done handshake, since a result takes multiple cycles.

---
 rtl/divider_if.sv | 25 ++
 rtl/divider.sv | 114 +++++++++++
 tb/tb_divider.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface divider_if #(
  parameter int unsigned BIT_SZ = 8
);
  logic              start;
  logic [BIT_SZ-1:0] a;
  logic [BIT_SZ-1:0] b;
  logic              ready;
  logic              done;
  logic [BIT_SZ-1:0] q;
  logic [BIT_SZ-1:0] r;
  logic              dbz;

  // Requester side: issues operands, observes results.
  modport master (
    output start, a, b,
    input  ready, done, q, r, dbz
  );

  // Divider side.
  modport slave (
    input  start, a, b,
    output ready, done, q, r, dbz
  );
endinterface

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module divider #(
  parameter int unsigned BIT_SZ = 8
) (
  input logic       clk,
  input logic       rst,
  divider_if.slave  bus
);
  localparam int unsigned CntW = $clog2(BIT_SZ);
  localparam logic [CntW-1:0] LastStep = CntW'(BIT_SZ - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

  state_t            state;
  // work holds the dividend bits still to be consumed in its upper part and the
  // quotient bits produced so far in its lower part; after BIT_SZ steps it is the quotient.
  logic [BIT_SZ-1:0] work;
  logic [BIT_SZ-1:0] divisor;
  // Stored partial remainder is always < divisor, so BIT_SZ bits suffice between steps.
  logic [BIT_SZ-1:0] rem;
  logic [CntW-1:0]   cnt;
  logic              ready_reg;
  logic              done_reg;
  logic [BIT_SZ-1:0] q_reg;
  logic [BIT_SZ-1:0] r_reg;
  logic              dbz_reg;

  logic [BIT_SZ:0]   rem_shift;
  logic [BIT_SZ:0]   rem_diff;
  logic              fits;
  logic [BIT_SZ-1:0] rem_next;
  logic [BIT_SZ-1:0] work_next;
  logic              accept;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep on no borrow.
  always_comb begin
    rem_shift = {rem, work[BIT_SZ-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    // The shifted remainder is below 2*divisor, so bit BIT_SZ of the difference is its sign.
    fits      = ~rem_diff[BIT_SZ];
    rem_next  = fits ? rem_diff[BIT_SZ-1:0] : rem_shift[BIT_SZ-1:0];
    work_next = {work[BIT_SZ-2:0], fits};
  end

  assign accept = bus.start && (state == StIdle || state == StDone);

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      work      <= '0;
      divisor   <= '0;
      rem       <= '0;
      cnt       <= '0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      q_reg     <= '0;
      r_reg     <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (accept) begin
            work    <= bus.a;
            divisor <= bus.b;
            rem     <= '0;
            cnt     <= '0;
            if (bus.b != '0) begin
              state     <= StCalc;
              ready_reg <= 1'b0;
              done_reg  <= 1'b0;
            end else begin
              // Divide by zero completes immediately with a defined result.
              state     <= StDone;
              ready_reg <= 1'b1;
              done_reg  <= 1'b1;
              q_reg     <= '1;
              r_reg     <= bus.a;
              dbz_reg   <= 1'b1;
            end
          end else begin
            state     <= StIdle;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        StCalc: begin
          work <= work_next;
          rem  <= rem_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LastStep) begin
            state     <= StDone;
            ready_reg <= 1'b1;
            done_reg  <= 1'b1;
            q_reg     <= work_next;
            r_reg     <= rem_next;
            dbz_reg   <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          ready_reg <= 1'b1;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_reg;
  assign bus.done  = done_reg;
  assign bus.q     = q_reg;
  assign bus.r     = r_reg;
  assign bus.dbz   = dbz_reg;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus randomized regression
// against a latency/arithmetic reference model.
module tb_divider;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cmp_en;

  divider_if #(.BIT_SZ(W)) dif ();

  divider #(.BIT_SZ(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: results from plain / and %, timing as a countdown of edges.
  logic         m_busy;
  int           m_left;
  logic         m_ready;
  logic         m_done;
  logic [W-1:0] m_q, m_r, m_pq, m_pr, m_pa, m_pb;
  logic         m_dbz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_left  <= 0;
      m_ready <= 1'b1;
      m_done  <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
      m_dbz   <= 1'b0;
      m_pq    <= '0;
      m_pr    <= '0;
      m_pa    <= '0;
      m_pb    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_ready <= 1'b1;
          m_q     <= m_pq;
          m_r     <= m_pr;
          m_dbz   <= 1'b0;
        end
      end else if (dif.start) begin
        m_pa <= dif.a;
        m_pb <= dif.b;
        if (dif.b == '0) begin
          m_done  <= 1'b1;
          m_ready <= 1'b1;
          m_q     <= '1;
          m_r     <= dif.a;
          m_dbz   <= 1'b1;
        end else begin
          m_busy  <= 1'b1;
          m_left  <= W;
          m_ready <= 1'b0;
          m_pq    <= dif.a / dif.b;
          m_pr    <= dif.a % dif.b;
        end
      end else begin
        m_ready <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst && cmp_en != 0) begin
      check("ready", 32'(dif.ready), 32'(m_ready));
      check("done", 32'(dif.done), 32'(m_done));
      check("q", 32'(dif.q), 32'(m_q));
      check("r", 32'(dif.r), 32'(m_r));
      check("dbz", 32'(dif.dbz), 32'(m_dbz));
      if (dif.done && m_pb != '0) begin
        check("a_eq_qb_plus_r", 32'(dif.q) * 32'(m_pb) + 32'(dif.r), 32'(m_pa));
        check("r_lt_b", 32'(dif.r < m_pb), 32'd1);
      end
    end
  end

  // Issue one operation from idle and wait (bounded) for done; check literal expectations.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz);
    int lat;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = av;
    dif.b     = bv;
    @(negedge clk);
    dif.start = 1'b0;
    dif.a     = W'($urandom);
    dif.b     = W'($urandom);
    lat = 1;
    while (!dif.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_q"}, 32'(dif.q), 32'(eq));
    check({name, "_r"}, 32'(dif.r), 32'(er));
    check({name, "_dbz"}, 32'(dif.dbz), 32'(edbz));
  endtask

  initial begin
    int lat;
    int ndone;
    vectors     = 0;
    miscompares = 0;
    cmp_en      = 0;
    rst         = 1'b1;
    dif.start   = 1'b0;
    dif.a       = '0;
    dif.b       = '0;
    #1;
    check("reset_ready", 32'(dif.ready), 32'd1);
    check("reset_done", 32'(dif.done), 32'd0);
    check("reset_q", 32'(dif.q), 32'd0);
    check("reset_r", 32'(dif.r), 32'd0);
    check("reset_dbz", 32'(dif.dbz), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1;

    run_op("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_q", 32'(dif.q), 32'd14);
    check("hold_r", 32'(dif.r), 32'd2);
    run_op("d255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
    run_op("d3_200", 8'd3, 8'd200, 9, 8'd0, 8'd3, 1'b0);
    run_op("d0_9", 8'd0, 8'd9, 9, 8'd0, 8'd0, 1'b0);
    run_op("d77_0", 8'd77, 8'd0, 1, 8'd255, 8'd77, 1'b1);
    run_op("d77_7", 8'd77, 8'd7, 9, 8'd11, 8'd0, 1'b0);
    run_op("d9_9", 8'd9, 8'd9, 9, 8'd1, 8'd0, 1'b0);

    // Requests during CALC must be ignored; operand changes must not matter.
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = 8'd200;
    dif.b     = 8'd3;
    @(negedge clk);
    lat = 1;
    while (!dif.done && lat < 40) begin
      check("busy_ready_low", 32'(dif.ready), 32'd0);
      dif.start = (lat == 3 || lat == 5);
      dif.a     = (lat == 3 || lat == 5) ? 8'd9 : W'($urandom);
      dif.b     = (lat == 3 || lat == 5) ? 8'd9 : W'($urandom);
      @(negedge clk);
      lat++;
    end
    dif.start = 1'b0;
    check("ign_latency", 32'(lat), 32'd9);
    check("ign_q", 32'(dif.q), 32'd66);
    check("ign_r", 32'(dif.r), 32'd2);
    @(negedge clk);
    check("ign_no_second_done", 32'(dif.done), 32'd0);

    // Reset in the middle of a calculation aborts it.
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = 8'd50;
    dif.b     = 8'd4;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(dif.q), 32'd0);
    check("mid_rst_r", 32'(dif.r), 32'd0);
    check("mid_rst_ready", 32'(dif.ready), 32'd1);
    check("mid_rst_done", 32'(dif.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op("d50_4", 8'd50, 8'd4, 9, 8'd12, 8'd2, 1'b0);

    // Randomized regression; start is held high often, so many ops start in the done cycle.
    ndone = 0;
    for (int cyc = 0; cyc < 40000 && ndone < 3000; cyc++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      @(negedge clk);
      if (dif.done) ndone++;
      ra = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 8'd1;
        2:       rb = ra;
        3:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      dif.start = ($urandom_range(0, 3) != 0);
      dif.a     = ra;
      dif.b     = rb;
    end
    check("random_ops_completed", 32'(ndone >= 3000), 32'd1);
    dif.start = 1'b0;
    repeat (12) @(negedge clk);
    cmp_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
